seq_checker: RTL and testbench
==============================

SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 8: sample data width.
REQ-002 SHALL have parameter LOCK_COUNT, default 4: consecutive matches needed to lock (range 1..15).
REQ-003 SHALL have parameter LOSS_COUNT, default 3: consecutive mismatches while locked that drop lock (range 1..15).
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port en, input, 1: sample strobe; data is valid this cycle.
REQ-007 SHALL have port data, input, WIDTH: incrementing-sequence value from the producer side.
REQ-008 SHALL have port clr, input, 1: synchronous clear of err_cnt.
REQ-009 SHALL have port locked, output, 1: checker is in LOCKED state.
REQ-010 SHALL have port err, output, 1: one-cycle pulse per mismatch detected while LOCKED.
REQ-011 SHALL have port err_cnt, output, 16: saturating mismatch count.
REQ-012 SHALL have port expected, output, WIDTH: value expected at the next en sample.

Function
REQ-013 SHALL register all outputs; each update is visible after the clk edge that sampled en=1.
REQ-014 SHALL implement two states: HUNT (locked=0) and LOCKED (locked=1).
REQ-015 SHALL hold an internal have_prev flag, cleared by reset; the first en sample after reset only loads expected <= data+1, sets have_prev, and performs no compare.
REQ-016 SHALL define match as data == expected; all arithmetic is modulo 2^WIDTH, so 0xFF is followed by 0x00 at WIDTH=8.
REQ-017 HUNT, en=1: expected <= data+1 (resync to received value); on match increment match_run, otherwise set match_run to 0.
REQ-018 HUNT -> LOCKED on the en sample that makes match_run reach LOCK_COUNT; match_run is cleared on entry.
REQ-019 LOCKED, en=1: expected <= expected+1 (flywheel, independent of data), so one corrupted sample yields exactly one error.
REQ-020 LOCKED, mismatch: err=1 for the following cycle, err_cnt increments by 1, miss_run increments by 1.
REQ-021 LOCKED, match: miss_run <= 0; err=0.
REQ-022 LOCKED -> HUNT on the mismatch that makes miss_run reach LOSS_COUNT; that mismatch still pulses err and counts; on the same edge expected <= data+1, and miss_run and match_run are cleared.
REQ-023 SHALL never assert err, and never increment err_cnt, in HUNT.
REQ-024 err_cnt SHALL saturate at 0xFFFF; err still pulses at saturation.
REQ-025 clr=1 SHALL set err_cnt to 0 and take priority over a simultaneous increment; err still pulses.
REQ-026 en=0: state, counters and expected SHALL hold; err SHALL be 0.

Reset
REQ-027 rst_n=0 SHALL immediately force locked=0, err=0, err_cnt=0, expected=0, state=HUNT, have_prev=0, match_run=0 and miss_run=0, independent of clk.
REQ-028 After rst_n deasserts, the first rising edge with en=1 SHALL be treated as the first sample (REQ-015).

Verification (WIDTH=8, LOCK_COUNT=4, LOSS_COUNT=3)
REQ-029 Lock acquisition: after reset, en=1 with data 0x10,0x11,0x12,0x13,0x14 on consecutive cycles -> locked=1 after the 0x14 edge (not earlier); expected=0x15; err never 1.
REQ-030 Wrap-around: locked, data 0xFE,0xFF,0x00,0x01 -> no err; err_cnt unchanged; expected=0x02.
REQ-031 Single glitch: locked with expected=0x20; data 0x55 then 0x21 -> exactly one err pulse; err_cnt=1; locked stays 1; expected=0x22.
REQ-032 Loss and relock: locked with expected=0x30; data 0x00,0x00,0x00 -> three err pulses, err_cnt +3, locked=0 after the third edge, expected=0x01; then data 0x01..0x04 -> locked=1 again.
REQ-033 Gaps, clear and saturation: en=0 for 5 cycles inside a locked run -> no change; err_cnt preloaded to 0xFFFF plus a mismatch -> stays 0xFFFF with err=1; clr=1 coincident with a mismatch -> err_cnt=0.
REQ-034 Asynchronous reset mid-lock: rst_n low between edges -> locked, err_cnt and expected read 0 before the next clk edge.

Source files
------------

// File: rtl/seq_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_checker                                                   |
// | Description : Incrementing-sequence checker with hunt/lock flywheel and     |
// |               saturating error counter.                                     |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module seq_checker #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [15:0]      err_cnt,
  output logic [WIDTH-1:0] expected
);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [3:0] c_lock_last = 4'(LOCK_COUNT - 1);
  localparam logic [3:0] c_loss_last = 4'(LOSS_COUNT - 1);

  state_t           r_state;
  logic             r_have_prev;
  logic [3:0]       r_match_run;
  logic [3:0]       r_miss_run;
  logic             r_err;
  logic [15:0]      r_err_cnt;
  logic [WIDTH-1:0] r_expected;

  logic             w_match;
  logic             w_cnt_sat;
  logic [WIDTH-1:0] w_data_inc;
  logic [WIDTH-1:0] w_exp_inc;

  assign w_match    = (data == r_expected);
  assign w_cnt_sat  = &r_err_cnt;
  assign w_data_inc = data + WIDTH'(1);
  assign w_exp_inc  = r_expected + WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= HUNT;
      r_have_prev <= 1'b0;
      r_match_run <= '0;
      r_miss_run  <= '0;
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
      r_expected  <= '0;
    end else begin
      r_err <= 1'b0;
      if (en) begin
        if (!r_have_prev) begin
          r_have_prev <= 1'b1;
          r_expected  <= w_data_inc;
        end else if (r_state == HUNT) begin
          // Hunting: always resync to whatever arrived.
          r_expected <= w_data_inc;
          if (w_match) begin
            if (r_match_run == c_lock_last) begin
              r_state     <= LOCKED;
              r_match_run <= '0;
            end else begin
              r_match_run <= r_match_run + 4'd1;
            end
          end else begin
            r_match_run <= '0;
          end
        end else begin
          if (w_match) begin
            r_miss_run <= '0;
            r_expected <= w_exp_inc;
          end else begin
            r_err <= 1'b1;
            if (!w_cnt_sat) begin
              r_err_cnt <= r_err_cnt + 16'd1;
            end
            if (r_miss_run == c_loss_last) begin
              r_state     <= HUNT;
              r_expected  <= w_data_inc;
              r_miss_run  <= '0;
              r_match_run <= '0;
            end else begin
              // Flywheel past an isolated corrupt sample.
              r_miss_run <= r_miss_run + 4'd1;
              r_expected <= w_exp_inc;
            end
          end
        end
      end
      if (clr) begin
        r_err_cnt <= '0;
      end
    end
  end

  assign locked   = (r_state == LOCKED);
  assign err      = r_err;
  assign err_cnt  = r_err_cnt;
  assign expected = r_expected;

endmodule
`default_nettype wire

// File: tb/tb_seq_checker.sv
`default_nettype none
// Self-checking bench for seq_checker: behavioural model plus directed vectors.
module tb_seq_checker;

  typedef struct {
    bit lk;
    bit have;
    int mrun;
    int xrun;
    int ex;
    int cnt;
    bit err;
  } mdl_t;

  logic        clk;
  logic        rst_n;
  logic        en1, clr1, en2, clr2;
  logic [7:0]  d1, d2;
  logic        locked1, err1, locked2, err2;
  logic [15:0] cnt1, cnt2;
  logic [7:0]  exp1, exp2;

  mdl_t m1, m2;
  int   vectors;
  int   miscompares;

  seq_checker #(.WIDTH(8), .LOCK_COUNT(4), .LOSS_COUNT(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en1), .data(d1), .clr(clr1),
    .locked(locked1), .err(err1), .err_cnt(cnt1), .expected(exp1)
  );

  // Second instance tuned so the 16-bit counter can be driven to saturation quickly.
  seq_checker #(.WIDTH(8), .LOCK_COUNT(1), .LOSS_COUNT(15)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en2), .data(d2), .clr(clr2),
    .locked(locked2), .err(err2), .err_cnt(cnt2), .expected(exp2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mdl_t mdl_reset();
    mdl_t s;
    s.lk = 0; s.have = 0; s.mrun = 0; s.xrun = 0; s.ex = 0; s.cnt = 0; s.err = 0;
    return s;
  endfunction

  function automatic mdl_t mdl_step(mdl_t s, bit e, int d, bit c, int lockc, int lossc);
    mdl_t n = s;
    n.err = 0;
    if (e) begin
      if (!s.have) begin
        n.have = 1;
        n.ex = (d + 1) % 256;
      end else if (!s.lk) begin
        n.ex = (d + 1) % 256;
        n.mrun = (d == s.ex) ? s.mrun + 1 : 0;
        if (n.mrun == lockc) begin
          n.lk = 1;
          n.mrun = 0;
        end
      end else if (d == s.ex) begin
        n.xrun = 0;
        n.ex = (s.ex + 1) % 256;
      end else begin
        n.err = 1;
        n.cnt = (s.cnt < 65535) ? s.cnt + 1 : 65535;
        n.xrun = s.xrun + 1;
        n.ex = (s.ex + 1) % 256;
        if (n.xrun == lossc) begin
          n.lk = 0;
          n.xrun = 0;
          n.mrun = 0;
          n.ex = (d + 1) % 256;
        end
      end
    end
    if (c) n.cnt = 0;
    return n;
  endfunction

  task automatic cmp(input string nm, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    cmp("locked", int'(locked1), int'(m1.lk));
    cmp("err", int'(err1), int'(m1.err));
    cmp("err_cnt", int'(cnt1), m1.cnt);
    cmp("expected", int'(exp1), m1.ex);
    cmp("sat_locked", int'(locked2), int'(m2.lk));
    cmp("sat_err", int'(err2), int'(m2.err));
    cmp("sat_err_cnt", int'(cnt2), m2.cnt);
    cmp("sat_expected", int'(exp2), m2.ex);
  end

  task automatic tick(input bit e1, input int v1, input bit c1,
                      input bit e2, input int v2, input bit c2);
    en1 = e1; d1 = 8'(v1); clr1 = c1;
    en2 = e2; d2 = 8'(v2); clr2 = c2;
    @(posedge clk);
    m1 = mdl_step(m1, e1, v1 & 255, c1, 4, 3);
    m2 = mdl_step(m2, e2, v2 & 255, c2, 1, 15);
    @(negedge clk);
  endtask

  task automatic t1(input bit e, input int v, input bit c);
    tick(e, v, c, 1'b0, 0, 1'b0);
  endtask

  task automatic t2(input bit e, input int v, input bit c);
    tick(1'b0, 0, 1'b0, e, v, c);
  endtask

  task automatic feed_to(input int target);
    int guard = 0;
    while (m1.ex != target && guard < 300) begin
      t1(1'b1, m1.ex, 1'b0);
      guard++;
    end
    cmp("feed_reached", m1.ex, target);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    m1 = mdl_reset();
    m2 = mdl_reset();
    rst_n = 1'b0;
    en1 = 0; d1 = 0; clr1 = 0; en2 = 0; d2 = 0; clr2 = 0;
    repeat (2) @(negedge clk);
    cmp("rst_locked", int'(locked1), 0);
    cmp("rst_err_cnt", int'(cnt1), 0);
    cmp("rst_expected", int'(exp1), 0);
    rst_n = 1'b1;

    // Lock acquisition
    for (int v = 8'h10; v <= 8'h13; v++) t1(1'b1, v, 1'b0);
    cmp("lock_not_early", int'(locked1), 0);
    t1(1'b1, 8'h14, 1'b0);
    cmp("lock_at_0x14", int'(locked1), 1);
    cmp("lock_expected", int'(exp1), 8'h15);

    // Wrap-around
    feed_to(8'hFE);
    t1(1'b1, 8'hFE, 1'b0); t1(1'b1, 8'hFF, 1'b0);
    t1(1'b1, 8'h00, 1'b0); t1(1'b1, 8'h01, 1'b0);
    cmp("wrap_expected", int'(exp1), 8'h02);
    cmp("wrap_err_cnt", int'(cnt1), 0);

    // Single glitch
    feed_to(8'h20);
    t1(1'b1, 8'h55, 1'b0);
    cmp("glitch_err", int'(err1), 1);
    cmp("glitch_cnt", int'(cnt1), 1);
    t1(1'b1, 8'h21, 1'b0);
    cmp("glitch_err_clear", int'(err1), 0);
    cmp("glitch_locked", int'(locked1), 1);
    cmp("glitch_expected", int'(exp1), 8'h22);

    // Gaps hold everything
    repeat (5) t1(1'b0, 8'hAA, 1'b0);
    cmp("gap_expected", int'(exp1), 8'h22);
    cmp("gap_locked", int'(locked1), 1);

    // Loss and relock
    feed_to(8'h30);
    t1(1'b1, 8'h00, 1'b0); t1(1'b1, 8'h00, 1'b0);
    cmp("loss_still_locked", int'(locked1), 1);
    t1(1'b1, 8'h00, 1'b0);
    cmp("loss_unlocked", int'(locked1), 0);
    cmp("loss_err", int'(err1), 1);
    cmp("loss_expected", int'(exp1), 8'h01);
    cmp("loss_cnt", int'(cnt1), 4);
    for (int v = 1; v <= 3; v++) t1(1'b1, v, 1'b0);
    cmp("relock_not_early", int'(locked1), 0);
    t1(1'b1, 8'h04, 1'b0);
    cmp("relock", int'(locked1), 1);
    cmp("relock_expected", int'(exp1), 8'h05);

    // Clear coincident with a mismatch
    t1(1'b1, 8'h99, 1'b1);
    cmp("clr_err", int'(err1), 1);
    cmp("clr_cnt", int'(cnt1), 0);
    cmp("clr_expected", int'(exp1), 8'h06);

    // Asynchronous reset between edges
    t1(1'b1, 8'h06, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    cmp("arst_locked", int'(locked1), 0);
    cmp("arst_cnt", int'(cnt1), 0);
    cmp("arst_expected", int'(exp1), 0);
    m1 = mdl_reset();
    m2 = mdl_reset();
    en1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    t1(1'b1, 8'h40, 1'b0);
    cmp("post_rst_load", int'(exp1), 8'h41);
    cmp("post_rst_hunt", int'(locked1), 0);
    for (int v = 8'h41; v <= 8'h44; v++) t1(1'b1, v, 1'b0);
    cmp("post_rst_relock", int'(locked1), 1);

    // Saturation on the second instance
    t2(1'b1, 8'h00, 1'b0);
    t2(1'b1, 8'h01, 1'b0);
    cmp("sat_lock", int'(locked2), 1);
    for (int b = 0; b < 4681; b++) begin
      repeat (14) t2(1'b1, m2.ex ^ 8'h80, 1'b0);
      t2(1'b1, m2.ex, 1'b0);
    end
    t2(1'b1, m2.ex ^ 8'h80, 1'b0);
    cmp("sat_reach", int'(cnt2), 16'hFFFF);
    t2(1'b1, m2.ex ^ 8'h80, 1'b0);
    cmp("sat_hold", int'(cnt2), 16'hFFFF);
    cmp("sat_err_pulse", int'(err2), 1);
    t2(1'b1, m2.ex ^ 8'h80, 1'b1);
    cmp("sat_clr", int'(cnt2), 0);
    cmp("sat_clr_err", int'(err2), 1);
    t2(1'b0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
